// File: rtl/wallace_acc_pkg.sv
// Shared types and widths for the approximate-MAC product accumulator.
`timescale 1ns/1ps

package wallace_acc_pkg;

    localparam int PROD_W    = 16;
    localparam int ACC_W_DEF = 24;
    localparam int CNT_W_DEF = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_t;

endpackage

// File: rtl/sat_acc_add.sv
// Combinational saturating add of a zero-extended 16-bit product onto an accumulator.
`timescale 1ns/1ps

module sat_acc_add
    import wallace_acc_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] addend,
    output logic [ACC_W-1:0]  sum,
    output logic              sat
);

    logic [ACC_W:0] full;

    // One extra bit catches the carry-out that triggers the clamp.
    assign full = {1'b0, acc} + (ACC_W + 1)'(addend);
    assign sat  = full[ACC_W];
    assign sum  = sat ? '1 : full[ACC_W-1:0];

endmodule

// File: rtl/wallace_product_accumulator.sv
// Burst accumulator for Wallace-tree multiplier products with a held valid/ready result register.
`timescale 1ns/1ps

// state | meaning
// IDLE  | working acc/cnt/ovf are zero, no beat of the current burst taken
// ACCUM | at least one beat taken, last beat not yet seen
module wallace_product_accumulator
    import wallace_acc_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [PROD_W-1:0] prod,
    input  logic              prod_last,
    input  logic              clr,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_sum,
    output logic [CNT_W-1:0]  res_count,
    output logic              res_ovf
);

    acc_state_t       state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic             take;
    logic             fresh;
    logic [ACC_W-1:0] acc_base;
    logic [CNT_W-1:0] cnt_base;
    logic             ovf_base;
    logic [ACC_W-1:0] sum_next;
    logic             sum_sat;
    logic [CNT_W-1:0] cnt_next;
    logic             cnt_sat;
    logic             ovf_next;

    assign prod_ready = !(res_valid && !res_ready);
    assign take       = prod_valid && prod_ready;

    // A beat arriving with clr (or in IDLE) starts a new sum from zero.
    assign fresh    = clr || (state == IDLE);
    assign acc_base = fresh ? '0 : acc;
    assign cnt_base = fresh ? '0 : cnt;
    assign ovf_base = fresh ? 1'b0 : ovf;

    sat_acc_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .acc    (acc_base),
        .addend (prod),
        .sum    (sum_next),
        .sat    (sum_sat)
    );

    assign cnt_sat  = &cnt_base;
    assign cnt_next = cnt_sat ? cnt_base : cnt_base + CNT_W'(1);
    assign ovf_next = ovf_base || sum_sat || cnt_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_count <= '0;
            res_ovf   <= 1'b0;
        end else begin
            if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end

            if (take) begin
                if (prod_last) begin
                    res_valid <= 1'b1;
                    res_sum   <= sum_next;
                    res_count <= cnt_next;
                    res_ovf   <= ovf_next;
                    state     <= IDLE;
                    acc       <= '0;
                    cnt       <= '0;
                    ovf       <= 1'b0;
                end else begin
                    state <= ACCUM;
                    acc   <= sum_next;
                    cnt   <= cnt_next;
                    ovf   <= ovf_next;
                end
            end else if (clr) begin
                state <= IDLE;
                acc   <= '0;
                cnt   <= '0;
                ovf   <= 1'b0;
            end
        end
    end

endmodule
